// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin arbitration.
// Define STREAM_MUX_CNT_EN to add the 16-bit accepted-transfer counter port xfer_count.
module stream_mux_rr #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [15:0]          xfer_count
`endif
);

    // Handshake: a word moves on a port in any cycle where valid and ready are both
    // high; valid never waits on ready, and ready may depend combinationally on valid.

    logic             load;
    logic             accept;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     grant_oh;
    logic [WIDTH-1:0] grant_data;
    int               cand;
    logic [SEL_W-1:0] cand_idx;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    assign load = ~out_valid_q | out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (mode == 1'b0) begin
            // An out-of-range sel matches no channel, so it simply yields no grant.
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Search starts just after the last served channel, wrapping modulo N.
            for (int k = 1; k <= N; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N) begin
                    cand = cand - N;
                end
                cand_idx = SEL_W'(cand);
                if (!grant_vld && in_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        grant_oh   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld && grant_idx == SEL_W'(i)) begin
                grant_oh[i] = 1'b1;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = rst ? '0 : (grant_oh & {N{load}});
    assign accept   = load & grant_vld;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                ptr_d      = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SEL_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, WIDTH=2): directed vectors plus a
// per-cycle behavioural model with an expected-word queue.
module tb_stream_mux_rr;
  localparam int N     = 4;
  localparam int WIDTH = 2;
  localparam int SEL_W = 2;
  localparam int WW    = SEL_W + WIDTH;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;
`ifdef STREAM_MUX_CNT_EN
  logic [15:0]        xfer_count;
`endif

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_MUX_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / behavioural model
  logic [WW-1:0] exp_q[$];
  logic          m_ok = 1'b0;
  logic          m_valid;
  logic [WW-1:0] m_word;
  int            m_last;
  logic [15:0]   m_cnt;

  always @(negedge clk) begin
    int            g;
    int            c;
    logic          ld;
    logic [N-1:0]  exp_rdy;
    logic [WW-1:0] w;
    g = -1;
    if (!rst) begin
      if (mode == 1'b0) begin
        if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
    end
    ld = !m_valid || out_ready;
    exp_rdy = '0;
    if (g >= 0 && ld) exp_rdy[g] = 1'b1;

    if (m_ok) begin
      chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_word", 32'({out_chan, out_data}), 32'(m_word));
`ifdef STREAM_MUX_CNT_EN
      chk("m_xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
      if (m_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("sb_queue_empty", 32'd0, 32'd1);
        end else begin
          w = exp_q.pop_front();
          chk("sb_word", 32'({out_chan, out_data}), 32'(w));
        end
      end
    end

    if (rst) begin
      m_valid = 1'b0;
      m_word  = '0;
      m_last  = N - 1;
      m_cnt   = '0;
      exp_q.delete();
    end else if (ld) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_word = {SEL_W'(g), in_data[g*WIDTH +: WIDTH]};
        m_last = g;
        m_cnt  = m_cnt + 16'd1;
        exp_q.push_back(m_word);
      end
    end
    m_ok = 1'b1;
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                       input logic r, input logic [N*WIDTH-1:0] d);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    in_data   = d;
  endtask

  typedef struct packed {
    logic               m;
    logic [SEL_W-1:0]   s;
    logic [N-1:0]       v;
    logic               r;
    logic [N*WIDTH-1:0] d;
  } vec_t;

  vec_t vecs[10];
  int   rr_exp[8]     = '{0, 1, 2, 3, 0, 1, 2, 3};
  int   sparse_exp[4] = '{3, 0, 3, 0};

  // ch0=01 ch1=10 ch2=11 ch3=00
  localparam logic [N*WIDTH-1:0] BASE_DATA = 8'b00_11_10_01;

  initial begin
    vecs[0] = '{1'b1, 2'd0, 4'b0000, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 2'd0, 4'b0100, 1'b1, 8'b00_10_00_00};
    vecs[2] = '{1'b1, 2'd0, 4'b0110, 1'b0, 8'b00_01_11_00};
    vecs[3] = '{1'b0, 2'd3, 4'b1000, 1'b1, 8'b11_00_00_00};
    vecs[4] = '{1'b0, 2'd0, 4'b1110, 1'b1, 8'b01_10_11_01};
    vecs[5] = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'b01_10_11_10};
    vecs[6] = '{1'b1, 2'd2, 4'b1010, 1'b1, 8'b10_01_01_11};
    vecs[7] = '{1'b1, 2'd2, 4'b1010, 1'b0, 8'b01_01_10_11};
    vecs[8] = '{1'b1, 2'd1, 4'b1010, 1'b1, 8'b11_00_00_00};
    vecs[9] = '{1'b1, 2'd1, 4'b0000, 1'b1, 8'b00_00_00_00};

    // reset with every channel valid
    rst = 1'b1;
    drive(1'b1, 2'd0, 4'b1111, 1'b1, BASE_DATA);
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 32'(in_ready), 32'b0001);

    // round-robin over all four channels
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      @(negedge clk);
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_chan", 32'(out_chan), 32'(rr_exp[k]));
    end

    // fixed select of channel 2
    next_cycle();
    drive(1'b0, 2'd2, 4'b1111, 1'b1, BASE_DATA);
    @(negedge clk);
    chk("fixed_in_ready", 32'(in_ready), 32'b0100);
    next_cycle();
    @(negedge clk);
    chk("fixed_out_data", 32'(out_data), 32'b11);
    chk("fixed_out_chan", 32'(out_chan), 32'd2);

    // sparse valid with wrap
    next_cycle();
    drive(1'b1, 2'd0, 4'b1001, 1'b1, BASE_DATA);
    @(negedge clk);
    chk("sparse_mask", 32'(in_ready & 4'b0110), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("sparse_chan", 32'(out_chan), 32'(sparse_exp[k]));
      chk("sparse_mask", 32'(in_ready & 4'b0110), 32'd0);
    end

    // backpressure while the setting changes under the held word
    next_cycle();
    drive(1'b0, 2'd1, 4'b1111, 1'b0, BASE_DATA);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_chan", 32'(out_chan), 32'd3);
      chk("bp_out_data", 32'(out_data), 32'b00);
      if (k < 3) next_cycle();
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    next_cycle();
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_chan", 32'(out_chan), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'b10);

    // reset mid-stream discards the held word
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_chan", 32'(out_chan), 32'd0);
`ifdef STREAM_MUX_CNT_EN
    chk("midrst_count", 32'(xfer_count), 32'd0);
`endif

    // directed vector table, checked by the model
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(vecs[k].m, vecs[k].s, vecs[k].v, vecs[k].r, vecs[k].d);
      @(negedge clk);
    end

`ifdef STREAM_MUX_CNT_EN
    // counter wrap after 65536 accepted transfers
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 2'd0, 4'b1111, 1'b1, BASE_DATA);
    @(negedge clk);
    chk("cnt_after_rst", 32'(xfer_count), 32'd0);
    repeat (65536) @(posedge clk);
    #1;
    @(negedge clk);
    chk("cnt_wrap", 32'(xfer_count), 32'd0);
`endif

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer. It generalises the team's 2-bit 2:1 combinational select into a valid/ready-handshaked selector with one output register stage. Two arbitration modes are provided: fixed select, and round-robin. It sits between multiple producer streams and a single consumer, and is the next-generation replacement for the hand-wired 2:1 muxes.

## Interface
Parameters:
- WIDTH, 2: data width per channel.
- N, 4: number of input channels (2..16).
- SEL_W, $clog2(N): select/channel-index width (derived; do not override).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, synchronous and active-high.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit set.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- xfer_count  output  16  accepted-transfer counter (only with STREAM_MUX_CNT_EN).

## Operation
- Transfer on a channel: in_valid[i] & in_ready[i]. Output transfer: out_valid & out_ready.
- load = ~out_valid | out_ready (the output register is empty or draining this cycle).
- Grant (combinational, one-hot or zero):
  - mode=0: grant = sel, if in_valid[sel]. If sel >= N, there is no grant.
  - mode=1: the first valid channel searching ascending from ptr+1, wrapping modulo N.
- in_ready[i] = grant[i] & load. No other channel sees ready.
- On a load with a grant: out_data <= granted data, out_chan <= index, out_valid <= 1, ptr <= index.
- On a load without a grant: out_valid <= 0. out_data and out_chan hold their values.
- ptr updates on every accepted transfer in both modes, so switching to mode=1 continues fairly from the last served channel.
- in_data and sel are sampled only in the accepting cycle. A change after acceptance does not affect the registered output.
- Changing mode or sel while out_valid=1 and out_ready=0 does not alter the held output. The new setting applies at the next load.
- Simultaneous out drain and in accept: both occur in the same cycle, with no bubble.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=N-1 (channel 0 has first priority), xfer_count=0. in_ready is 0 while rst=1.
- rst asserted mid-stream discards the held output word. No in_ready is asserted in the reset cycle.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, the output is stable and all in_ready=0.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is served exactly once per N cycles.
- The in_ready path is combinational from in_valid, mode, sel and out_ready. out_* outputs are registered only.

## Configuration
- STREAM_MUX_CNT_EN defined: xfer_count increments by 1 on each input acceptance and wraps from 16'hFFFF to 0. It resets to 0.
- STREAM_MUX_CNT_EN undefined: the xfer_count port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles with all in_valid=1 -> out_valid=0, in_ready=0, out_data=0. After release, the first accepted channel is 0.
- Fixed mode: N=4, WIDTH=2, mode=0, sel=2, in_data ch2=2'b11, all valid, out_ready=1 -> only in_ready[2]=1. The next cycle gives out_data=2'b11, out_chan=2.
- Round-robin: all 4 valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
- Sparse and wrap: in_valid=4'b1001, mode=1 -> out_chan alternates 0,3,0,3. Channels 1 and 2 never get ready.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan stable, all in_ready=0. Raise out_ready -> same-cycle drain and accept of the next channel.
- Counter (STREAM_MUX_CNT_EN): preload via 65536 accepted transfers -> xfer_count wraps to 0. Reset mid-run -> xfer_count=0.
